// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle main controller: opcodes, FSM states,
// ALU/operand select codes and access sizes.
// Optional macro DWORD_EN: enables the doubleword access size for LD/SD.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_DADDI = 6'b011000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LD    = 6'b110111;
   localparam logic [5:0] OP_SD    = 6'b111111;

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
      StAluWb, StImmExec, StImmWb, StBranch, StJump, StIllegal, StFault
   } state_t;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_AND   = 3'b001;
   localparam logic [2:0] ALU_OR    = 3'b010;
   localparam logic [2:0] ALU_SLT   = 3'b011;
   localparam logic [2:0] ALU_SUB   = 3'b110;
   localparam logic [2:0] ALU_FUNCT = 3'b111;

   localparam logic [2:0] SRCB_REGB    = 3'b000;
   localparam logic [2:0] SRCB_FOUR    = 3'b001;
   localparam logic [2:0] SRCB_SIMM    = 3'b010;
   localparam logic [2:0] SRCB_ZIMM    = 3'b011;
   localparam logic [2:0] SRCB_SIMM_SH = 3'b100;

   localparam logic [1:0] SZ_NONE  = 2'b00;
   localparam logic [1:0] SZ_WORD  = 2'b01;
   localparam logic [1:0] SZ_BYTE  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic is_load(input logic [5:0] o);
      return (o == OP_LW) || (o == OP_LB) || (o == OP_LBU) || (o == OP_LD);
   endfunction

   // Access size for a load/store opcode; SZ_NONE for anything else.
   function automatic logic [1:0] mem_size(input logic [5:0] o);
      logic [1:0] sz;
      case (o)
         OP_LW, OP_SW:         sz = SZ_WORD;
         OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
`ifdef DWORD_EN
         OP_LD, OP_SD:         sz = SZ_DWORD;
`else
         // without doubleword support these never reach a memory state
`endif
         default:              sz = SZ_NONE;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags a timeout
// on the cycle the count would reach MEM_TIMEOUT with memory still not ready.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic mem_ready,
   output logic timeout
);

   localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;

   // ready in the same cycle wins over the timeout
   assign timeout = active && !mem_ready && (cnt_q == LIMIT);

   // Clear whenever outside a memory state or the access ends, so every
   // memory state is entered with a zero count.
   always_comb begin
      cnt_d = cnt_q;
      if (!active || mem_ready || timeout) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with memory-ready timeout, sticky illegal/fault states
// and a retired-instruction counter.
// Optional macro DWORD_EN: makes LD, SD and DADDI legal.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             branch_eq,
   output logic             branch_ne,
   output logic [1:0]       pcsrc,
   output logic             iord,
   output logic             memread,
   output logic [1:0]       memwrite,
   output logic [1:0]       load_size,
   output logic             load_signed,
   output logic             irwrite,
   output logic             regdst,
   output logic             memtoreg,
   output logic             regwrite,
   output logic             alusrca,
   output logic [2:0]       alusrcb,
   output logic [2:0]       aluop,
   output logic             illegal,
   output logic             fault,
   output logic [CNT_W-1:0] instret
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             retire;
   logic             wait_active;
   logic             timeout;

   function automatic state_t decode_next(input logic [5:0] o);
      state_t n;
      case (o)
         OP_RTYPE:                               n = StExec;
         OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB:     n = StMemAdr;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:      n = StImmExec;
         OP_BEQ, OP_BNE:                         n = StBranch;
         OP_J:                                   n = StJump;
`ifdef DWORD_EN
         OP_LD, OP_SD:                           n = StMemAdr;
         OP_DADDI:                               n = StImmExec;
`else
         // doubleword opcodes fall through to illegal
`endif
         default:                                n = StIllegal;
      endcase
      return n;
   endfunction

   assign wait_active = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
   assign instret     = instret_q;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .active   (wait_active),
      .mem_ready(mem_ready),
      .timeout  (timeout)
   );

   // Next-state and Moore outputs; reset low forces every control to 0.
   always_comb begin
      state_d     = state_q;
      retire      = 1'b0;
      pcwrite     = 1'b0;
      branch_eq   = 1'b0;
      branch_ne   = 1'b0;
      pcsrc       = PCSRC_ALU;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = SZ_NONE;
      load_size   = SZ_NONE;
      load_signed = 1'b0;
      irwrite     = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = SRCB_REGB;
      aluop       = ALU_ADD;
      illegal     = 1'b0;
      fault       = 1'b0;
      unique case (state_q)
         StFetch: begin
            memread = 1'b1;
            alusrcb = SRCB_FOUR;
            if (mem_ready) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               state_d = StDecode;
            end else if (timeout) begin
               state_d = StFault;
            end
         end
         StDecode: begin
            alusrcb = SRCB_SIMM_SH;
            state_d = decode_next(op);
         end
         StMemAdr: begin
            alusrca = 1'b1;
            alusrcb = SRCB_SIMM;
            state_d = is_load(op) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            memread     = 1'b1;
            iord        = 1'b1;
            load_size   = mem_size(op);
            load_signed = (op == OP_LB);
            if (mem_ready) begin
               state_d = StMemWb;
            end else if (timeout) begin
               state_d = StFault;
            end
         end
         StMemWb: begin
            regwrite  = 1'b1;
            memtoreg  = 1'b1;
            load_size = mem_size(op);
            state_d   = StFetch;
            retire    = 1'b1;
         end
         StMemWr: begin
            iord     = 1'b1;
            memwrite = mem_size(op);
            if (mem_ready) begin
               state_d = StFetch;
               retire  = 1'b1;
            end else if (timeout) begin
               state_d = StFault;
            end
         end
         StExec: begin
            alusrca = 1'b1;
            aluop   = ALU_FUNCT;
            state_d = StAluWb;
         end
         StAluWb: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            state_d  = StFetch;
            retire   = 1'b1;
         end
         StImmExec: begin
            alusrca = 1'b1;
            case (op)
               OP_ANDI: begin alusrcb = SRCB_ZIMM; aluop = ALU_AND; end
               OP_ORI:  begin alusrcb = SRCB_ZIMM; aluop = ALU_OR;  end
               OP_SLTI: begin alusrcb = SRCB_SIMM; aluop = ALU_SLT; end
               default: begin alusrcb = SRCB_SIMM; aluop = ALU_ADD; end
            endcase
            state_d = StImmWb;
         end
         StImmWb: begin
            regwrite = 1'b1;
            state_d  = StFetch;
            retire   = 1'b1;
         end
         StBranch: begin
            alusrca   = 1'b1;
            aluop     = ALU_SUB;
            pcsrc     = PCSRC_ALUOUT;
            branch_eq = (op == OP_BEQ);
            branch_ne = (op == OP_BNE);
            state_d   = StFetch;
            retire    = 1'b1;
         end
         StJump: begin
            pcwrite = 1'b1;
            pcsrc   = PCSRC_JUMP;
            state_d = StFetch;
            retire  = 1'b1;
         end
         StIllegal: illegal = 1'b1;
         StFault:   fault   = 1'b1;
         default:   state_d = StFetch;
      endcase
      if (!reset) begin
         pcwrite     = 1'b0;
         branch_eq   = 1'b0;
         branch_ne   = 1'b0;
         pcsrc       = 2'b00;
         iord        = 1'b0;
         memread     = 1'b0;
         memwrite    = 2'b00;
         load_size   = 2'b00;
         load_signed = 1'b0;
         irwrite     = 1'b0;
         regdst      = 1'b0;
         memtoreg    = 1'b0;
         regwrite    = 1'b0;
         alusrca     = 1'b0;
         alusrcb     = 3'b000;
         aluop       = 3'b000;
         illegal     = 1'b0;
         fault       = 1'b0;
      end
   end

   // State and retired-instruction counter with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StFetch;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle main decoder.
- Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Adds byte, word and doubleword load/store sizing, BNE, a memory-ready handshake with timeout fault, sticky illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register opcode field and the multicycle datapath.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready in any memory state before entering FAULT; legal range 1..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- op  in  6  opcode field of the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- pcwrite  out  1  unconditional PC load.
- branch_eq  out  1  PC load if ALU zero.
- branch_ne  out  1  PC load if not ALU zero.
- pcsrc  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- memread  out  1  memory read request.
- memwrite  out  2  00 none, 01 word, 10 byte, 11 doubleword.
- load_size  out  2  01 word, 10 byte, 11 doubleword; valid in MEMRD/MEMWB.
- load_signed  out  1  sign-extend a byte load.
- irwrite  out  1  instruction register load.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  writeback from memory data.
- regwrite  out  1  register file write.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  3  000 regB, 001 const 4, 010 signimm, 011 zeroimm, 100 signimm<<2.
- aluop  out  3  000 add, 001 and, 010 or, 011 slt, 110 sub, 111 use funct.
- illegal  out  1  sticky unsupported opcode.
- fault  out  1  sticky memory timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: while reset = 0 at a rising edge, state becomes FETCH, instret = 0, wait counter = 0, illegal = fault = 0.
- During a reset-low cycle, every control output is forced to 0 combinationally. This overrides any state, including a reset taken mid-access.
- All other control outputs are a pure function of the state (Moore). Unlisted outputs are 0.
- FETCH:
  - Outputs: memread, iord=0, alusrca=0, alusrcb=001, aluop=000.
  - irwrite and pcwrite assert only in the cycle mem_ready = 1; the FSM then goes to DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE:
  - Outputs: alusrca=0, alusrcb=100, aluop=000, which computes the branch target into ALUOut.
  - Next state by op: RTYPE→EXEC; LW/LB/LBU/SW/SB/LD/SD→MEMADR; ADDI/DADDI/ANDI/ORI/SLTI→IMMEXEC; BEQ/BNE→BRANCH; J→JUMP.
  - Any other op→ILLEGAL.
- MEMADR: alusrca=1, alusrcb=010, aluop=000. Loads go to MEMRD, stores to MEMWR.
- MEMRD:
  - Outputs: memread, iord=1, load_size/load_signed from op (LB signed, LBU unsigned).
  - Holds until mem_ready, then goes to MEMWB.
- MEMWB: regwrite, memtoreg, regdst=0, load_size held; then FETCH.
- MEMWR: iord=1, memwrite = size from op; holds until mem_ready, then FETCH.
- EXEC: alusrca=1, alusrcb=000, aluop=111; then ALUWB.
- ALUWB: regwrite, regdst=1; then FETCH.
- IMMEXEC:
  - alusrca=1.
  - ADDI/DADDI: alusrcb=010, aluop=000. SLTI: alusrcb=010, aluop=011.
  - ANDI: alusrcb=011, aluop=001. ORI: alusrcb=011, aluop=010.
  - Next state IMMWB.
- IMMWB: regwrite, regdst=0; then FETCH.
- BRANCH: alusrca=1, alusrcb=000, aluop=110, pcsrc=01, branch_eq (BEQ) or branch_ne (BNE); then FETCH.
- JUMP: pcwrite, pcsrc=10; then FETCH.
- ILLEGAL and FAULT:
  - Terminal states; only reset exits them.
  - illegal or fault = 1, all other controls 0.
- Wait counter:
  - Cleared on entry to FETCH/MEMRD/MEMWR; increments each cycle in those states while mem_ready = 0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, the next state is FAULT.
  - mem_ready = 1 in the same cycle wins over the timeout.
- instret: increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, IMMWB, BRANCH or JUMP. Wraps modulo 2^CNT_W.
- Latency in cycles with zero-wait memory: R-type 4, immediate 4, load 5, store 4, branch 3, jump 3. Each memory wait cycle adds 1.

Optional Feature:
- DWORD_EN defined:
  - LD, SD and DADDI are legal.
  - LD uses load_size=11 and SD uses memwrite=11; DADDI behaves as ADDI.
- DWORD_EN undefined:
  - LD, SD and DADDI decode to ILLEGAL.
  - The values 11 never appear on memwrite or load_size.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (RTYPE, LW, LB, LBU, SW, SB, LD, SD, BEQ, BNE, J, ADDI, DADDI, ANDI, ORI, SLTI);
  - the state_t enum;
  - the aluop, alusrcb and size encodings.
- One sub-module, mem_wait_timer: the wait counter plus timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset low for 2 cycles mid-MEMRD → all outputs 0; after release, state FETCH and instret=0.
- op=000000 with mem_ready tied 1 → FETCH, DECODE, EXEC, ALUWB, FETCH; regwrite=1, regdst=1 in cycle 4; instret=1.
- op=100100 (LBU) with mem_ready low 3 cycles in MEMRD → 8 cycles total; load_size=10, load_signed=0, memtoreg=1 in MEMWB.
- op=000101 (BNE) → BRANCH asserts branch_ne=1, aluop=110, pcsrc=01, with branch_eq=0.
- op=111111 (SD):
  - DWORD_EN undefined → illegal=1, held for 10 cycles until reset.
  - DWORD_EN defined → memwrite=11 in MEMWR.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → fault=1 after 4 wait cycles. With mem_ready=1 exactly on cycle 4 → DECODE, no fault.
